// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Synchronises and debounces five push-buttons, then emits
//            one-cycle step pulses with auto-repeat on the directions.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 7_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_btn_up,
    input  logic       in_btn_down,
    input  logic       in_btn_left,
    input  logic       in_btn_right,
    input  logic       in_selected,
    output logic       step_up,
    output logic       step_down,
    output logic       step_left,
    output logic       step_right,
    output logic       step_select,
    output logic [4:0] held
);

    localparam int c_NCHAN   = 5;
    localparam int c_SEL     = 4;
    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX);

    localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_ONE     = c_DB_W'(1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LOAD = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RATE_LOAD  = c_RPT_W'(REPEAT_RATE - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_ONE    = c_RPT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronisation, bit order {select, right, left, down, up}
    // ------------------------------------------------------------------------
    logic [c_NCHAN-1:0] w_raw;
    logic [c_NCHAN-1:0] r_meta;
    logic [c_NCHAN-1:0] r_sync;
    logic [c_NCHAN-1:0] w_db;

    assign w_raw = {in_selected, in_btn_right, in_btn_left, in_btn_down, in_btn_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debouncer: state flips after DEBOUNCE_CYCLES disagreeing
    // samples in a row; any agreeing sample restarts the count.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_NCHAN; gi++) begin : g_chan
            logic              r_d;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_d   <= 1'b0;
                    r_cnt <= '0;
                end else if (r_sync[gi] != r_d) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_d   <= ~r_d;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DB_ONE;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_db[gi] = r_d;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Select: rising-edge detector, no repeat
    // ------------------------------------------------------------------------
    logic r_sel_prev;
    logic r_step_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_prev <= 1'b0;
            r_step_sel <= 1'b0;
        end else begin
            r_sel_prev <= w_db[c_SEL];
            r_step_sel <= w_db[c_SEL] & ~r_sel_prev;
        end
    end

    // ------------------------------------------------------------------------
    // Shared direction repeat FSM
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic [c_RPT_W-1:0] w_rpt_cnt_nxt;
    logic [3:0]         r_dir;
    logic [3:0]         w_dir_nxt;
    logic [3:0]         r_step_dir;
    logic [3:0]         w_step_dir_nxt;
    logic [3:0]         w_dirs;
    logic               w_single;

    assign w_dirs   = w_db[3:0];
    assign w_single = $onehot(w_dirs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rpt_cnt  <= '0;
            r_dir      <= '0;
            r_step_dir <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rpt_cnt  <= w_rpt_cnt_nxt;
            r_dir      <= w_dir_nxt;
            r_step_dir <= w_step_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rpt_cnt_nxt  = r_rpt_cnt;
        w_dir_nxt      = r_dir;
        w_step_dir_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_single) begin
                    w_step_dir_nxt = w_dirs;
                    w_dir_nxt      = w_dirs;
                    w_rpt_cnt_nxt  = c_DELAY_LOAD;
                    w_state_nxt    = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // r_dir is one-hot, so any change in the held set aborts
                if (w_dirs != r_dir) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_rpt_cnt == '0) begin
                    w_step_dir_nxt = r_dir;
                    w_rpt_cnt_nxt  = c_RATE_LOAD;
                    w_state_nxt    = ST_REPEAT;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt - c_RPT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign step_up     = r_step_dir[0];
    assign step_down   = r_step_dir[1];
    assign step_left   = r_step_dir[2];
    assign step_right  = r_step_dir[3];
    assign step_select = r_step_sel;
    assign held        = w_db;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Directed self-checking bench for btn_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic       in_btn_up, in_btn_down, in_btn_left, in_btn_right, in_selected;
    logic       step_up, step_down, step_left, step_right, step_select;
    logic [4:0] held;
    logic [4:0] steps;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_btn_up   (in_btn_up),
        .in_btn_down (in_btn_down),
        .in_btn_left (in_btn_left),
        .in_btn_right(in_btn_right),
        .in_selected (in_selected),
        .step_up     (step_up),
        .step_down   (step_down),
        .step_left   (step_left),
        .step_right  (step_right),
        .step_select (step_select),
        .held        (held)
    );

    assign steps = {step_select, step_right, step_left, step_down, step_up};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic [4:0] obs,
                         input logic [4:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_held"}, i, held, 5'b0);
            check({tag, "_step"}, i, steps, 5'b0);
        end
    endtask

    initial begin
        logic [4:0] exp_h;
        logic [4:0] exp_s;

        rst          = 1'b1;
        in_btn_up    = 1'b0;
        in_btn_down  = 1'b0;
        in_btn_left  = 1'b0;
        in_btn_right = 1'b0;
        in_selected  = 1'b0;

        // Reset, then keep reset asserted with up pressed
        tick();
        tick();
        check("rst_held", 0, held, 5'b0);
        check("rst_step", 0, steps, 5'b0);
        in_btn_up = 1'b1;
        idle_check("rst_up", 3);
        rst       = 1'b0;
        in_btn_up = 1'b0;
        idle_check("post_rst", 10);

        // Up held 40 cycles: press latency, delay, repeat rate, release
        for (int k = 0; k <= 55; k++) begin
            in_btn_up = (k < 40);
            tick();
            exp_h    = '0;
            exp_s    = '0;
            exp_h[0] = (k >= 5) && (k < 45);
            exp_s[0] = (k == 6) || ((k >= 16) && (k <= 41) && ((k - 16) % 5 == 0));
            check("up_held", k, held, exp_h);
            check("up_step", k, steps, exp_s);
        end
        idle_check("up_after", 5);

        // Left glitching 3 high / 1 low never debounces
        for (int k = 0; k < 40; k++) begin
            in_btn_left = ((k % 4) != 3);
            tick();
            check("glitch_held", k, held, 5'b0);
            check("glitch_step", k, steps, 5'b0);
        end
        in_btn_left = 1'b0;
        idle_check("glitch_after", 8);

        // Right, then right+down ambiguity, then down alone restarts
        for (int k = 0; k <= 60; k++) begin
            in_btn_right = (k < 25);
            in_btn_down  = (k >= 10) && (k < 47);
            tick();
            exp_h    = '0;
            exp_s    = '0;
            exp_h[3] = (k >= 5) && (k < 30);
            exp_h[1] = (k >= 15) && (k < 52);
            exp_s[3] = (k == 6);
            exp_s[1] = (k == 31) || (k == 41) || (k == 46) || (k == 51);
            check("multi_held", k, held, exp_h);
            check("multi_step", k, steps, exp_s);
        end
        idle_check("multi_after", 5);

        // Select held 50 cycles: single pulse, none on release
        for (int k = 0; k <= 65; k++) begin
            in_selected = (k < 50);
            tick();
            exp_h    = '0;
            exp_s    = '0;
            exp_h[4] = (k >= 5) && (k < 55);
            exp_s[4] = (k == 6);
            check("sel_held", k, held, exp_h);
            check("sel_step", k, steps, exp_s);
        end

        // Select and up together pulse in the same cycle
        for (int k = 0; k <= 20; k++) begin
            in_selected = (k < 10);
            in_btn_up   = (k < 10);
            tick();
            exp_h    = '0;
            exp_s    = '0;
            exp_h[4] = (k >= 5) && (k < 15);
            exp_h[0] = (k >= 5) && (k < 15);
            exp_s[4] = (k == 6);
            exp_s[0] = (k == 6);
            check("both_held", k, held, exp_h);
            check("both_step", k, steps, exp_s);
        end
        idle_check("both_after", 5);

        // Reset mid-repeat with up held through it: re-press after release
        for (int k = 0; k <= 20; k++) begin
            in_btn_up = 1'b1;
            rst       = (k == 8) || (k == 9);
            tick();
            exp_h    = '0;
            exp_s    = '0;
            exp_h[0] = ((k >= 5) && (k < 8)) || (k >= 15);
            exp_s[0] = (k == 6) || (k == 16);
            check("midrst_held", k, held, exp_h);
            check("midrst_step", k, steps, exp_s);
        end
        in_btn_up = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        idle_check("final", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
